// File: rtl/avalon_mem_responder.sv
//----------------------------------------------------------------------------
// avalon_mem_responder
//
// Avalon-MM pipelined-read slave with 16-bit data, backed by a DEPTH-word
// on-chip memory. This is the responder end of the SDRAM master interface
// used by the node-accumulator engine. It doubles as a bench-side SDRAM
// stand-in and as a fast on-chip weight/result buffer.
//
// Reads are sampled from memory at the accepting edge and returned exactly
// READ_LAT cycles later with a one-cycle readdatavalid pulse. Up to MAX_PEND
// reads may be outstanding; beyond that waitrequest holds the master off.
//
// Optional build macro:
//   AVMM_STALL_INJECT_EN - when defined, a 16-bit LFSR adds pseudo-random
//                          stall cycles (~25%) to waitrequest.
//
// Parameters:
//   ADDR_W    word-address width
//   DEPTH     memory words; addresses >= DEPTH are out of range
//   READ_LAT  acceptance-to-readdatavalid latency (1..8)
//   MAX_PEND  maximum outstanding reads (1..READ_LAT+1)
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   chipselect     slave select; strobes are ignored when low
//   read_n         read request, active low
//   write_n        write request, active low (wins over a concurrent read)
//   address        word address
//   byteenable     write lane enables (bit0 = [7:0], bit1 = [15:8])
//   writedata      write data
//   waitrequest    stall; master must hold the command
//   readdata       read data, qualified by readdatavalid, holds otherwise
//   readdatavalid  one-cycle pulse per accepted read
//   pend_cnt       accepted reads not yet returned
//   addr_err       sticky flag: an out-of-range access was accepted
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module avalon_mem_responder #(
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 3,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [ADDR_W-1:0] address,
    input  logic [1:0]        byteenable,
    input  logic [15:0]       writedata,
    output logic              waitrequest,
    output logic [15:0]       readdata,
    output logic              readdatavalid,
    output logic [3:0]        pend_cnt,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Two-state controller: INIT holds off the master for the first cycle
    // after reset, RUN is normal operation.
    localparam logic [0:0] ST_INIT = 1'b1;
    localparam logic [0:0] ST_RUN  = 1'b0;

    localparam logic [3:0]        PEND_LIMIT = 4'(MAX_PEND);
    // One extra bit so DEPTH is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_EXT  = (ADDR_W + 1)'(DEPTH);

    logic [0:0]          state_reg;
    logic [3:0]          pend_reg;
    logic [3:0]          pend_next;
    logic                addr_err_reg;
    logic                rdv_reg;
    logic [15:0]         rdata_reg;

    // vld_reg[k] marks a read that was accepted k+1 edges ago.
    logic [READ_LAT-1:0] vld_reg;
    // Out-of-range tag for the read sitting in stage 0.
    logic                oor_reg;

    logic [15:0]         mem_rd_data;
    logic [15:0]         stage0_data;
    logic [15:0]         tail_data;
    logic                tail_vld;

    logic                cmd_req;
    logic                accept;
    logic                wr_accept;
    logic                rd_accept;
    logic                in_range;
    logic                stall_extra;
    logic [IDX_W-1:0]    mem_idx;

    //------------------------------------------------------------------------
    // Command decode
    //------------------------------------------------------------------------
    assign cmd_req   = chipselect & (~read_n | ~write_n);
    assign accept    = cmd_req & ~waitrequest;
    // A simultaneous read+write is taken as a write only.
    assign wr_accept = accept & ~write_n;
    assign rd_accept = accept & write_n & ~read_n;
    assign in_range  = ({1'b0, address} < DEPTH_EXT);
    assign mem_idx   = address[IDX_W-1:0];

    //------------------------------------------------------------------------
    // Backpressure. Decided purely from registered state so the master sees
    // a clean, glitch-free stall; a retire in the current cycle does not
    // free a slot until the next one.
    //------------------------------------------------------------------------
    assign waitrequest = (state_reg == ST_INIT) | (pend_reg == PEND_LIMIT) | stall_extra;

`ifdef AVMM_STALL_INJECT_EN
    // Fibonacci LFSR, taps 16,14,13,11. Stalls whenever the low two bits are
    // zero, i.e. roughly one cycle in four.
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_reg <= 16'hACE1;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
        end
    end

    assign stall_extra = (lfsr_reg[1:0] == 2'b00);
`else
    assign stall_extra = 1'b0;
`endif

    //------------------------------------------------------------------------
    // Init / run controller
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_INIT;
        end else begin
            state_reg <= ST_RUN;
        end
    end

    //------------------------------------------------------------------------
    // Memory: one byte-wide array per lane so each lane is an independent
    // simple dual-port RAM with a registered read. Reads and writes never
    // occur in the same cycle, so read-during-write ordering is irrelevant.
    // Contents are deliberately not reset.
    //------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_accept && in_range && byteenable[gi]) begin
                    mem[mem_idx] <= writedata[gi*8 +: 8];
                end
                if (rd_accept) begin
                    rd_byte_reg <= mem[mem_idx];
                end
            end

            assign mem_rd_data[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    // Out-of-range reads return zero; the RAM output is ignored for them.
    assign stage0_data = oor_reg ? 16'h0000 : mem_rd_data;

    //------------------------------------------------------------------------
    // Latency pipeline: valid bits carry reset, data stages do not need it.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_reg <= '0;
            oor_reg <= 1'b0;
        end else begin
            vld_reg <= (vld_reg << 1) | READ_LAT'(rd_accept);
            oor_reg <= rd_accept & ~in_range;
        end
    end

    assign tail_vld = vld_reg[READ_LAT-1];

    generate
        if (READ_LAT == 1) begin : g_short
            assign tail_data = stage0_data;
        end else begin : g_long
            logic [15:0] dat_reg [1:READ_LAT-1];

            always_ff @(posedge clk) begin
                dat_reg[1] <= stage0_data;
                for (int k = 2; k < READ_LAT; k++) begin
                    dat_reg[k] <= dat_reg[k-1];
                end
            end

            assign tail_data = dat_reg[READ_LAT-1];
        end
    endgenerate

    //------------------------------------------------------------------------
    // Outstanding-read counter. A read stops counting at the edge that
    // raises its readdatavalid, so a full-rate stream peaks at READ_LAT.
    //------------------------------------------------------------------------
    always_comb begin
        pend_next = pend_reg;
        case ({rd_accept, tail_vld})
            2'b10:   pend_next = pend_reg + 4'd1;
            2'b01:   pend_next = pend_reg - 4'd1;
            default: pend_next = pend_reg;
        endcase
    end

    //------------------------------------------------------------------------
    // Response and status registers
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdv_reg      <= 1'b0;
            rdata_reg    <= 16'h0000;
            pend_reg     <= 4'd0;
            addr_err_reg <= 1'b0;
        end else begin
            rdv_reg  <= tail_vld;
            pend_reg <= pend_next;
            // readdata holds between returns.
            if (tail_vld) begin
                rdata_reg <= tail_data;
            end
            if (accept && !in_range) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

    assign readdatavalid = rdv_reg;
    assign readdata      = rdata_reg;
    assign pend_cnt      = pend_reg;
    assign addr_err      = addr_err_reg;

endmodule

// File: tb/tb_avalon_mem_responder.sv
//----------------------------------------------------------------------------
// tb_avalon_mem_responder
//
// Two responders share clock and reset: instance 0 uses MAX_PEND=4 and
// instance 1 uses MAX_PEND=2 (both READ_LAT=3, DEPTH=1024). A per-instance
// reference model tracks memory contents, addr_err and accepted reads;
// every accepted read pushes its expected data and due cycle onto a queue
// that is popped when readdatavalid is due. Outputs are sampled on the
// falling edge, inputs are driven 1ns after the rising edge.
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_avalon_mem_responder;

    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int L     = 3;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] addr;
        logic [15:0] data;
        logic        known;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cs;
    logic [1:0]  rn;
    logic [1:0]  wn;
    logic [AW-1:0] addr [2];
    logic [1:0]  be [2];
    logic [15:0] wdata [2];

    wire  [1:0]  wreq;
    wire  [1:0]  rdv;
    wire  [1:0]  aerr;
    wire  [15:0] rdata [2];
    wire  [3:0]  pend [2];

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit ran_edge = 1'b0;

    always #5 clk = ~clk;

    // Cycle counter and "a rising edge has happened out of reset" flag.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            ran_edge = !reset;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    //------------------------------------------------------------------------
    // DUT instances and per-instance scoreboard
    //------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int MP = (gi == 0) ? 4 : 2;

            exp_t        sbq [$];
            logic [15:0] mdl_mem   [DEPTH];
            bit   [1:0]  mdl_known [DEPTH];
            int          acc;
            int          ret;
            int          rdv_seen;
            bit          err_m;

            avalon_mem_responder #(
                .ADDR_W   (AW),
                .DEPTH    (DEPTH),
                .READ_LAT (L),
                .MAX_PEND (MP)
            ) dut (
                .clk           (clk),
                .reset         (reset),
                .chipselect    (cs[gi]),
                .read_n        (rn[gi]),
                .write_n       (wn[gi]),
                .address       (addr[gi]),
                .byteenable    (be[gi]),
                .writedata     (wdata[gi]),
                .waitrequest   (wreq[gi]),
                .readdata      (rdata[gi]),
                .readdatavalid (rdv[gi]),
                .pend_cnt      (pend[gi]),
                .addr_err      (aerr[gi])
            );

            initial begin
                bit   exp_v;
                bit   exp_w;
                bit   in_rng;
                int   pend_exp;
                int   idx;
                exp_t e;
                acc      = 0;
                ret      = 0;
                rdv_seen = 0;
                err_m    = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rdv[gi]) rdv_seen++;
                    if (reset) begin
                        sbq.delete();
                        acc   = 0;
                        ret   = 0;
                        err_m = 1'b0;
                        check_eq("rst_rdv",  32'(rdv[gi]),  32'd0);
                        check_eq("rst_pend", 32'(pend[gi]), 32'd0);
                        check_eq("rst_wait", 32'(wreq[gi]), 32'd1);
                        check_eq("rst_aerr", 32'(aerr[gi]), 32'd0);
                    end else begin
                        // Returns due this cycle.
                        exp_v = (sbq.size() != 0) && (sbq[0].due == 32'(cyc));
                        check_eq("rdv", 32'(rdv[gi]), 32'(exp_v));
                        if (exp_v) begin
                            e = sbq.pop_front();
                            ret++;
                            if (e.known) check_eq("rdata", 32'(rdata[gi]), 32'(e.data));
                            $display("[%0t] inst%0d read addr=%0d data=%h expected=%h", $time, gi, e.addr, rdata[gi], e.data);
                        end
                        pend_exp = acc - ret;
                        check_eq("pend", 32'(pend[gi]), 32'(pend_exp));
                        exp_w = !ran_edge || (pend_exp == MP);
`ifdef AVMM_STALL_INJECT_EN
                        if (exp_w) check_eq("wait", 32'(wreq[gi]), 32'd1);
`else
                        check_eq("wait", 32'(wreq[gi]), 32'(exp_w));
`endif
                        check_eq("aerr", 32'(aerr[gi]), 32'(err_m));

                        // Command that the next rising edge will accept.
                        if (cs[gi] && !wreq[gi] && (!rn[gi] || !wn[gi])) begin
                            in_rng = (addr[gi] < DEPTH);
                            idx    = int'(addr[gi][9:0]);
                            if (!in_rng) err_m = 1'b1;
                            if (!wn[gi]) begin
                                if (in_rng) begin
                                    if (be[gi][0]) begin
                                        mdl_mem[idx][7:0] = wdata[gi][7:0];
                                        mdl_known[idx][0] = 1'b1;
                                    end
                                    if (be[gi][1]) begin
                                        mdl_mem[idx][15:8] = wdata[gi][15:8];
                                        mdl_known[idx][1] = 1'b1;
                                    end
                                end
                            end else begin
                                e.due   = 32'(cyc + 1 + L);
                                e.addr  = addr[gi];
                                e.known = !in_rng || (mdl_known[idx] == 2'b11);
                                e.data  = in_rng ? mdl_mem[idx] : 16'h0000;
                                sbq.push_back(e);
                                acc++;
                            end
                        end
                    end
                end
            end
        end
    endgenerate

    //------------------------------------------------------------------------
    // Stimulus helpers (called 1ns after a rising edge)
    //------------------------------------------------------------------------
    task automatic idle(input int i);
        cs[i] = 1'b0;
        rn[i] = 1'b1;
        wn[i] = 1'b1;
        be[i] = 2'b00;
    endtask

    // Presents a command and holds it until accepted; returns stall count.
    task automatic cmd(input int i, input bit do_rd, input bit do_wr, input logic [31:0] a,
                       input logic [1:0] b, input logic [15:0] d, output int stalls);
        cs[i]    = 1'b1;
        rn[i]    = !do_rd;
        wn[i]    = !do_wr;
        addr[i]  = a;
        be[i]    = b;
        wdata[i] = d;
        stalls   = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!wreq[i]) begin
                @(posedge clk);
                #1;
                return;
            end
            stalls++;
            @(posedge clk);
            #1;
        end
        check_eq("cmd_timeout", 32'(stalls), 32'd0);
    endtask

    task automatic wr(input int i, input int a, input logic [15:0] d, input logic [1:0] b);
        int st;
        cmd(i, 1'b0, 1'b1, 32'(a), b, d, st);
    endtask

    task automatic rd(input int i, input int a, output int st);
        cmd(i, 1'b1, 1'b0, 32'(a), 2'b00, 16'h0000, st);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    //------------------------------------------------------------------------
    // Main sequence
    //------------------------------------------------------------------------
    initial begin
        int st;
        int total;
        int lat;
        int peak;
        int snap;
        bit found;

        cs = 2'b00;
        rn = 2'b11;
        wn = 2'b11;
        for (int i = 0; i < 2; i++) begin
            addr[i]  = '0;
            be[i]    = 2'b00;
            wdata[i] = 16'h0000;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset release with a read already being offered.
        cs[0]   = 1'b1;
        rn[0]   = 1'b0;
        wn[0]   = 1'b1;
        addr[0] = 32'd9;
        reset   = 1'b0;
        @(negedge clk);
        check_eq("init_wait", 32'(wreq[0]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
`ifndef AVMM_STALL_INJECT_EN
        check_eq("run_wait", 32'(wreq[0]), 32'd0);
`endif
        for (int k = 0; k < 20 && wreq[0]; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        idle(0);
        lat   = 0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge clk);
            if (rdv[0]) found = 1'b1;
            else        lat++;
        end
        check_eq("first_lat", 32'(lat), 32'd3);
        wait_cycles(3);

        // Byte-lane merge.
        wr(0, 5, 16'h1234, 2'b11);
        wr(0, 5, 16'hABCD, 2'b01);
        rd(0, 5, st);
        idle(0);
        wait_cycles(6);
        check_eq("t2_aerr", 32'(aerr[0]), 32'd0);

        // Full-rate read stream on instance 0.
        for (int a = 0; a < 8; a++) wr(0, a, 16'(a), 2'b11);
        idle(0);
        wait_cycles(2);
        total = 0;
        peak  = 0;
        fork
            begin
                for (int a = 0; a < 8; a++) begin
                    rd(0, a, st);
                    total += st;
                end
                idle(0);
            end
            begin
                found = 1'b0;
                for (int k = 0; k < 40 && !found; k++) begin
                    @(negedge clk);
                    if (int'(pend[0]) > peak) peak = int'(pend[0]);
                    if (rdv[0]) found = 1'b1;
                end
`ifndef AVMM_STALL_INJECT_EN
                check_eq("b2b_first", 32'(found), 32'd1);
                for (int j = 0; j < 8; j++) begin
                    if (j > 0) @(negedge clk);
                    if (int'(pend[0]) > peak) peak = int'(pend[0]);
                    check_eq("b2b_valid", 32'(rdv[0]), 32'd1);
                    check_eq("b2b_data", 32'(rdata[0]), 32'(j));
                end
`endif
            end
        join
        wait_cycles(6);
`ifndef AVMM_STALL_INJECT_EN
        check_eq("b2b_stalls", 32'(total), 32'd0);
        check_eq("b2b_peak", 32'(peak), 32'd3);
`endif

        // MAX_PEND=2 instance under continuous reads.
        for (int i = 0; i < 10; i++) wr(1, 100 + i, 16'h0100 + 16'(i), 2'b11);
        idle(1);
        wait_cycles(2);
        snap  = g_inst[1].rdv_seen;
        total = 0;
        for (int i = 0; i < 10; i++) begin
            rd(1, 100 + i, st);
            total += st;
        end
        idle(1);
        wait_cycles(8);
        check_eq("mp2_stalled", 32'(total > 0), 32'd1);
        check_eq("mp2_count", 32'(g_inst[1].rdv_seen - snap), 32'd10);
        check_eq("mp2_drain", 32'(g_inst[1].sbq.size()), 32'd0);

        // Out-of-range read, then a dropped out-of-range write.
        wr(0, 976, 16'h5A5A, 2'b11);
        rd(0, 2000, st);
        idle(0);
        wait_cycles(6);
        check_eq("oor_aerr", 32'(aerr[0]), 32'd1);
        wr(0, 2000, 16'hFFFF, 2'b11);
        rd(0, 976, st);
        idle(0);
        wait_cycles(6);
        check_eq("oor_sticky", 32'(aerr[0]), 32'd1);

        // Asynchronous reset with reads in flight.
        for (int a = 0; a < 4; a++) rd(0, a, st);
        idle(0);
`ifndef AVMM_STALL_INJECT_EN
        check_eq("pre_rst_rdv", 32'(rdv[0]), 32'd1);
        check_eq("pre_rst_pend", 32'(pend[0]), 32'd3);
`endif
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_rdv", 32'(rdv[0]), 32'd0);
        check_eq("arst_pend", 32'(pend[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        snap  = g_inst[0].rdv_seen;
        wait_cycles(12);
        check_eq("no_stray", 32'(g_inst[0].rdv_seen - snap), 32'd0);
        check_eq("sb0_empty", 32'(g_inst[0].sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
- Avalon-MM pipelined-read slave with 16-bit data. It is the responder end of the SDRAM master interface used by the node-accumulator engine.
- Backs a DEPTH-word on-chip memory.
- Honours chipselect/read_n/write_n/byteenable, applies waitrequest backpressure and returns read data with fixed latency via readdatavalid.
- Serves as a bench-side SDRAM stand-in and as a fast on-chip weight/result buffer.

Parameters:
- ADDR_W, 32: address port width (word address).
- DEPTH, 1024: memory words. Addresses >= DEPTH are out of range.
- READ_LAT, 3: cycles from read acceptance to readdatavalid (legal range 1..8).
- MAX_PEND, 4: maximum outstanding reads (legal range 1..READ_LAT+1).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous active-high reset.
- chipselect, input, 1: slave select.
- read_n, input, 1: read request (active low).
- write_n, input, 1: write request (active low).
- address, input, ADDR_W: word address.
- byteenable, input, 2: byte lanes for writes (bit0 = [7:0], bit1 = [15:8]).
- writedata, input, 16: write data.
- waitrequest, output, 1: stall; the master must hold the command.
- readdata, output, 16: read data, valid only with readdatavalid.
- readdatavalid, output, 1: one-cycle pulse per accepted read.
- pend_cnt, output, 4: outstanding accepted-but-unreturned reads.
- addr_err, output, 1: sticky flag, set on any accepted out-of-range access.

Interface rule (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset values, applied asynchronously: readdatavalid=0, readdata=0, pend_cnt=0, addr_err=0, latency pipeline valid bits=0, init flag=1. Memory contents are not reset.
- waitrequest = init | (pend_cnt == MAX_PEND), combinational from registered state. init clears on the first clk edge after reset deasserts, so waitrequest=1 during reset and for that first cycle.
- Acceptance: a command is accepted when chipselect=1, waitrequest=0 and read_n=0 or write_n=0.
- When chipselect=0, both strobes are ignored.
- read_n=0 and write_n=0 together: treated as a write only; the read is dropped and pend_cnt is not incremented.
- Write: on accept, for each byteenable bit set, mem[address][lane] <= writedata[lane]. byteenable=00 is a no-op write.
- Read: on accept, mem[address] is sampled at that edge. The data enters a READ_LAT-stage shift pipeline; readdatavalid=1 with readdata exactly READ_LAT cycles later.
- Back-to-back reads accepted every cycle return every cycle, in order.
- Read-after-write: a write accepted at cycle t is visible to a read accepted at cycle t+1. Same-cycle read+write follows the write-wins rule above.
- Out of range (address >= DEPTH): writes are dropped; reads return 16'h0000 with normal latency and valid; addr_err is set in both cases. addr_err clears only on reset.
- pend_cnt: +1 on accepted read, -1 on readdatavalid. Both in the same cycle leaves it unchanged.
- pend_cnt never exceeds MAX_PEND or goes below 0.
- waitrequest uses pre-edge pend_cnt. At MAX_PEND, a command offered in the same cycle as a retire is still stalled and is accepted the next cycle.
- waitrequest has no other source; there is no arbitration or state machine beyond init/RUN.
- Reset mid-operation: all in-flight reads are discarded, and no readdatavalid appears after reset.
- readdata holds its last value when readdatavalid=0.

Optional Feature:
- Macro: AVMM_STALL_INJECT_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle. Whenever lfsr[1:0]==2'b00, it ORs an extra stall term into waitrequest, stalling about 25% of cycles. The rest of the behaviour is unchanged.
- Not defined: no LFSR logic exists, and waitrequest is exactly as specified above.

Test Plan:
- Reset released, chipselect=1, read_n=0 held: waitrequest=1 for the first cycle, then 0. The first readdatavalid arrives exactly READ_LAT=3 cycles after acceptance.
- Write addr 5 = 16'h1234 with byteenable=11, then write addr 5 = 16'hABCD with byteenable=01, then read addr 5: readdata=16'h12CD after 3 cycles, addr_err=0.
- Eight back-to-back reads of addr 0..7 preloaded with value = addr, MAX_PEND=4, READ_LAT=3: waitrequest never asserts; readdatavalid is continuous for 8 cycles returning 0..7 in order; pend_cnt peaks at 3.
- MAX_PEND=2, READ_LAT=3, continuous reads: waitrequest=1 whenever pend_cnt=2. No command is lost, every accepted read returns exactly once, and the data order matches address order.
- Read of addr 2000 (DEPTH=1024): readdata=16'h0000 with readdatavalid, addr_err=1 sticky. A following write to addr 2000 is dropped and does not alias to any in-range word.
- Reset asserted while 3 reads are pending: readdatavalid=0 and pend_cnt=0 immediately, with no stray readdatavalid afterward. With AVMM_STALL_INJECT_EN defined, the same read stream still returns all data in order.
